// File: rtl/phase_sequencer.sv
// phase_sequencer: instruction phase generator for the VeriRISC CPU.
// Run/step/halt control, memory stall handling, timeout fault, retire count.
module phase_sequencer #(
   parameter int PHASE_WIDTH = 3,
   parameter int WAIT_MAX    = 15,
   parameter int COUNT_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   step,
   input  logic                   halt,
   input  logic                   mem_busy,
   output logic [PHASE_WIDTH-1:0] phase,
   output logic                   running,
   output logic                   halted,
   output logic                   fault,
   output logic                   instr_done,
   output logic [COUNT_WIDTH-1:0] instr_count
);

   typedef enum logic [2:0] {
      IDLE,
      RUN,
      STEP,
      HALTED,
      FAULT
   } state_t;

   localparam logic [PHASE_WIDTH-1:0] PH_ZERO = '0;
   localparam logic [PHASE_WIDTH-1:0] PH_HALT = PHASE_WIDTH'(4);
   localparam logic [PHASE_WIDTH-1:0] PH_LAST = '1;
   localparam logic [7:0]             WAIT_LAST = 8'(WAIT_MAX - 1);

   state_t     state;
   logic [7:0] wait_cnt;
   logic       mem_phase;
   logic       stall;
   logic       halt_hit;
   logic       retire;

   // Phases 0 and 4 never touch memory, so mem_busy cannot stall them.
   assign mem_phase = (phase != PH_ZERO) && (phase != PH_HALT);
   assign stall     = mem_busy && mem_phase;
   assign halt_hit  = halt && (phase == PH_HALT);
   assign retire    = halt_hit || (phase == PH_LAST);

   // Sequencer FSM with all outputs registered alongside the state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         phase       <= '0;
         wait_cnt    <= '0;
         instr_count <= '0;
         running     <= 1'b0;
         halted      <= 1'b0;
         fault       <= 1'b0;
         instr_done  <= 1'b0;
      end else begin
         instr_done <= 1'b0;
         unique case (state)
            IDLE, HALTED: begin
               if (start) begin
                  state   <= RUN;
                  running <= 1'b1;
                  halted  <= 1'b0;
               end else if (step) begin
                  state   <= STEP;
                  running <= 1'b1;
                  halted  <= 1'b0;
               end
            end
            RUN, STEP: begin
               if (stall) begin
                  if (wait_cnt == WAIT_LAST) begin
                     state   <= FAULT;
                     running <= 1'b0;
                     fault   <= 1'b1;
                  end else begin
                     wait_cnt <= wait_cnt + 8'd1;
                  end
               end else begin
                  wait_cnt <= '0;
                  if (retire) begin
                     phase       <= '0;
                     instr_count <= instr_count + 1'b1;
                     instr_done  <= 1'b1;
                     if (halt_hit || state == STEP) begin
                        state   <= HALTED;
                        running <= 1'b0;
                        halted  <= 1'b1;
                     end
                  end else begin
                     phase <= phase + 1'b1;
                  end
               end
            end
            FAULT: begin
               state <= FAULT;
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
               halted  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed and random checks of phase_sequencer
// against a behavioural model of the run/step/halt/stall rules.
module tb_phase_sequencer;

   localparam int PW = 3;
   localparam int WM = 15;
   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          step = 1'b0;
   logic          halt = 1'b0;
   logic          mem_busy = 1'b0;
   logic [PW-1:0] phase;
   logic          running;
   logic          halted;
   logic          fault;
   logic          instr_done;
   logic [CW-1:0] instr_count;

   int passed = 0;
   int total  = 0;

   // Model: mode 0 idle, 1 run, 2 single step, 3 halted, 4 faulted.
   int m_mode, m_phase, m_wait, m_cnt;
   bit m_done;

   phase_sequencer #(
      .PHASE_WIDTH(PW),
      .WAIT_MAX(WM),
      .COUNT_WIDTH(CW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .step(step),
      .halt(halt),
      .mem_busy(mem_busy),
      .phase(phase),
      .running(running),
      .halted(halted),
      .fault(fault),
      .instr_done(instr_done),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic check_all(input string tag);
      check({tag, ".phase"}, int'(phase), m_phase);
      check({tag, ".running"}, int'(running), int'(m_mode == 1 || m_mode == 2));
      check({tag, ".halted"}, int'(halted), int'(m_mode == 3));
      check({tag, ".fault"}, int'(fault), int'(m_mode == 4));
      check({tag, ".done"}, int'(instr_done), int'(m_done));
      check({tag, ".count"}, int'(instr_count), m_cnt);
   endtask

   task automatic m_reset();
      m_mode = 0; m_phase = 0; m_wait = 0; m_cnt = 0; m_done = 0;
   endtask

   // Next-state of the model for the inputs present at the coming edge.
   task automatic m_edge();
      bit memph;
      m_done = 0;
      memph = !(m_phase == 0 || m_phase == 4);
      if (m_mode == 0 || m_mode == 3) begin
         if (start) m_mode = 1;
         else if (step) m_mode = 2;
      end else if (m_mode == 1 || m_mode == 2) begin
         if (mem_busy && memph) begin
            if (m_wait + 1 >= WM) m_mode = 4;
            else m_wait++;
         end else begin
            m_wait = 0;
            if (m_phase == 4 && halt) begin
               m_phase = 0; m_cnt = (m_cnt + 1) % (1 << CW); m_done = 1;
               m_mode = 3;
            end else if (m_phase == 7) begin
               m_phase = 0; m_cnt = (m_cnt + 1) % (1 << CW); m_done = 1;
               if (m_mode == 2) m_mode = 3;
            end else begin
               m_phase++;
            end
         end
      end
   endtask

   task automatic tick(input string tag);
      m_edge();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Reset asserted between edges; outputs must clear without a clock.
   task automatic async_reset(input string tag);
      rst = 1'b1;
      #1;
      m_reset();
      check_all(tag);
      rst = 1'b0;
      #1;
   endtask

   task automatic run_to(input int ph, input string tag);
      int n;
      n = 0;
      while (m_phase != ph && n < 20) begin
         tick(tag);
         n++;
      end
      check({tag, ".reach"}, int'(phase), ph);
   endtask

   initial begin
      m_reset();
      #1;
      check_all("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Free run: three instructions in 24 cycles after entering RUN.
      start = 1'b1;
      tick("start");
      start = 1'b0;
      for (int i = 0; i < 8; i++) tick("run1");
      check("run1.done", int'(instr_done), 1);
      check("run1.cnt", int'(instr_count), 1);
      for (int i = 0; i < 16; i++) tick("run3");
      check("run3.cnt", int'(instr_count), 3);

      // Halt at phase 4, then resume.
      run_to(4, "to4");
      halt = 1'b1;
      tick("halt");
      halt = 1'b0;
      check("halt.halted", int'(halted), 1);
      check("halt.phase", int'(phase), 0);
      start = 1'b1;
      tick("resume");
      start = 1'b0;
      tick("resume1");
      check("resume.phase", int'(phase), 1);

      // halt outside phase 4 is ignored.
      halt = 1'b1;
      tick("halt_ign");
      halt = 1'b0;

      // Stall at phase 2 for three cycles; no stall at phase 4.
      run_to(2, "to2");
      mem_busy = 1'b1;
      for (int i = 0; i < 3; i++) tick("stall2");
      mem_busy = 1'b0;
      check("stall.hold", int'(phase), 2);
      tick("stall_rel");
      check("stall.adv", int'(phase), 3);
      tick("to4b");
      mem_busy = 1'b1;
      tick("busy4");
      mem_busy = 1'b0;
      check("busy4.phase", int'(phase), 5);

      // Step ignored while running; then halt and single-step.
      step = 1'b1;
      tick("step_ign");
      step = 1'b0;
      run_to(4, "to4c");
      halt = 1'b1;
      tick("halt2");
      halt = 1'b0;
      step = 1'b1;
      tick("step");
      step = 1'b0;
      for (int i = 0; i < 8; i++) tick("stepi");
      check("step.halted", int'(halted), 1);
      for (int i = 0; i < 10; i++) tick("idle");
      check("idle.phase", int'(phase), 0);

      // Timeout at phase 6.
      start = 1'b1;
      tick("start2");
      start = 1'b0;
      run_to(6, "to6");
      mem_busy = 1'b1;
      for (int i = 0; i < 14; i++) tick("stall6");
      check("pre_fault", int'(fault), 0);
      tick("stall6_last");
      check("fault.set", int'(fault), 1);
      check("fault.phase", int'(phase), 6);
      mem_busy = 1'b0;
      start = 1'b1;
      step = 1'b1;
      for (int i = 0; i < 4; i++) tick("fault_hold");
      start = 1'b0;
      step = 1'b0;
      async_reset("fault_rst");

      // Count wrap after 16 instructions, then async reset at phase 5.
      start = 1'b1;
      tick("start3");
      start = 1'b0;
      for (int i = 0; i < 128; i++) tick("wrap");
      check("wrap.cnt", int'(instr_count), 0);
      check("wrap.done", int'(instr_done), 1);
      run_to(5, "to5");
      async_reset("mid_rst");

      // Random stimulus against the model.
      for (int i = 0; i < 3000; i++) begin
         start    = ($urandom_range(0, 15) == 0);
         step     = ($urandom_range(0, 7) == 0);
         halt     = ($urandom_range(0, 3) == 0);
         mem_busy = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 199) == 0) mem_busy = 1'b1;
         tick("rand");
         if (m_mode == 4 && $urandom_range(0, 3) == 0) async_reset("rand_rst");
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
